dcache_bank: RTL and testbench
==============================

// Module: dcache_bank
// PURPOSE
//  Parametrised data-cache bank for the CPU datapath: word-addressed storage with byte-enabled STR,
//  registered LDR with valid/ready handshakes and back-pressure, and a sequential zeroise sweep
//  (after reset and on demand). Sits between the execute/uop stage and the register write-back stage.
// PARAMETERS
//  DATA_WIDTH  32                 word width in bits; multiple of 8
//  DEPTH       32                 number of words; any value >= 2
//  ADDR_WIDTH  $clog2(DEPTH)      request address width
// PORTS
//  clock       in   1             single clock; all state on posedge
//  reset_n     in   1             asynchronous, active-low reset
//  req_valid   in   1             request present
//  req_ready   out  1             bank accepts request this cycle
//  req_uop     in   5             Utilities::LDR or Utilities::STR; any other code is a NOP
//  req_addr    in   ADDR_WIDTH    word address
//  req_wdata   in   DATA_WIDTH    STR data
//  req_be      in   DATA_WIDTH/8  STR byte enables; ignored for LDR
//  resp_valid  out  1             load response present
//  resp_ready  in   1             consumer takes response
//  resp_rdata  out  DATA_WIDTH    load data
//  resp_err    out  1             load address >= DEPTH
//  store_err   out  1             one-cycle pulse: STR to address >= DEPTH dropped
//  clear_start in   1             request zeroise sweep
//  clear_busy  out  1             sweep in progress
// BEHAVIOUR
//  Reset (reset_n=0, async): state=CLEAR, clear pointer=0; resp_valid=0, resp_rdata=0, resp_err=0,
//   store_err=0, clear_busy=1, req_ready=0. Array contents are not reset directly; the sweep zeroes them.
//  FSM states:
//   CLEAR: writes 0 to word[ptr] each cycle, ptr++. After writing word DEPTH-1 -> IDLE.
//    Exactly DEPTH cycles. clear_busy=1, req_ready=0. clear_start is ignored.
//   IDLE: serves requests. clear_start=1 -> CLEAR with ptr=0 on the next edge.
//    clear_start takes priority: req_ready=0 in any cycle where clear_start=1.
//    A response already held in the output register is unaffected by a sweep.
//  Accept = req_valid & req_ready. In IDLE with clear_start=0, req_ready is:
//   1 for STR and NOP;
//   1 for LDR when resp_valid=0, or when resp_valid & resp_ready (pipelined: one LDR per cycle).
//  STR accepted, addr<DEPTH: for each i with be[i]=1, byte i of word[addr] <= wdata byte i. No response.
//  STR accepted, addr>=DEPTH: nothing is written; store_err=1 for the following cycle.
//  LDR accepted: next cycle resp_valid=1.
//   addr<DEPTH: resp_rdata = word[addr], resp_err=0.
//   addr>=DEPTH: resp_rdata = 0, resp_err=1.
//   Latency is exactly 1 cycle.
//  Output register: resp_valid/rdata/err hold stable while resp_valid & ~resp_ready.
//   resp_valid clears on resp_ready unless a new LDR is accepted in the same cycle.
//  Ordering: a STR accepted in cycle N is visible to a LDR accepted in cycle N+1 or later.
//   Only one request is accepted per cycle, so there is no same-cycle read/write hazard.
//  NOP uop: accepted and has no effect; no response.
//  Reset asserted mid-operation: pending response is dropped and a fresh sweep starts once reset_n=1.
// TESTING
//  1 Release reset: clear_busy=1 for exactly DEPTH(32) cycles, req_ready=0 throughout;
//    then LDR to every address returns 0 with resp_err=0.
//  2 STR addr 5 = 0xDEADBEEF, be=4'b1111; then STR addr 5 = 0x000000AA, be=4'b0001;
//    LDR addr 5 -> resp_rdata=0xDEADBEAA one cycle after accept.
//  3 Back-to-back LDR 1,2,3 with resp_ready held 0 after the first response:
//    req_ready=0 and rdata stays word[1]; raise resp_ready -> responses 1,2,3 in order, none lost or duplicated.
//  4 DEPTH=24: LDR addr 30 -> resp_err=1, rdata=0. STR addr 30 -> store_err pulses once;
//    a read of every word shows no change.
//  5 clear_start and STR addr 3 asserted together in IDLE: STR not accepted, sweep runs 32 cycles;
//    afterwards word[3]=0. Reset asserted mid-sweep restarts the sweep from ptr 0.
//  6 Random LDR/STR/NOP traffic with random resp_ready against a reference model:
//    data, response order and error flags all match.

Source files
------------

// File: rtl/dcache_bank_if.sv
// +--------------------------------------------------------------------------+
// | dcache_bank_if : request/response/zeroise bundle of the data-cache bank  |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

interface dcache_bank_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  logic                      req_valid;
  logic                      req_ready;
  logic [4:0]                req_uop;
  logic [ADDR_WIDTH-1:0]     req_addr;
  logic [DATA_WIDTH-1:0]     req_wdata;
  logic [DATA_WIDTH/8-1:0]   req_be;
  logic                      resp_valid;
  logic                      resp_ready;
  logic [DATA_WIDTH-1:0]     resp_rdata;
  logic                      resp_err;
  logic                      store_err;
  logic                      clear_start;
  logic                      clear_busy;

  modport master (
    output req_valid, req_uop, req_addr, req_wdata, req_be, resp_ready, clear_start,
    input  req_ready, resp_valid, resp_rdata, resp_err, store_err, clear_busy
  );

  modport slave (
    input  req_valid, req_uop, req_addr, req_wdata, req_be, resp_ready, clear_start,
    output req_ready, resp_valid, resp_rdata, resp_err, store_err, clear_busy
  );
endinterface

`default_nettype wire

// File: rtl/dcache_bank.sv
// +--------------------------------------------------------------------------+
// | dcache_bank : word-addressed data-cache bank, byte-enabled stores,       |
// |               registered loads with back-pressure, zeroise sweep         |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module dcache_bank #(
  parameter int         DATA_WIDTH = 32,
  parameter int         DEPTH      = 32,
  parameter int         ADDR_WIDTH = $clog2(DEPTH),
  parameter logic [4:0] LDR_UOP    = 5'd1,
  parameter logic [4:0] STR_UOP    = 5'd2
) (
  input  wire logic    clock,
  input  wire logic    reset_n,
  dcache_bank_if.slave bus
);

  localparam int                    BE_WIDTH    = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH-1:0] c_last_addr = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [ADDR_WIDTH-1:0] r_ptr;
  logic [ADDR_WIDTH-1:0] w_ptr_next;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic                  w_is_ldr;
  logic                  w_is_str;
  logic                  w_in_range;
  logic                  w_accept;
  logic                  w_ldr_acc;
  logic                  w_str_acc;
  logic                  w_clear_wr;
  logic                  w_req_ready;
  logic                  w_clear_busy;

  logic                  r_resp_valid;
  logic [DATA_WIDTH-1:0] r_resp_rdata;
  logic                  r_resp_err;
  logic                  r_store_err;

  assign w_is_ldr   = (bus.req_uop == LDR_UOP);
  assign w_is_str   = (bus.req_uop == STR_UOP);
  // Extra top bit keeps the compare meaningful when DEPTH is a power of two.
  assign w_in_range = ({1'b0, bus.req_addr} < (ADDR_WIDTH + 1)'(DEPTH));
  assign w_accept   = bus.req_valid & w_req_ready;
  assign w_ldr_acc  = w_accept & w_is_ldr;
  assign w_str_acc  = w_accept & w_is_str;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_CLEAR;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_next;
      r_ptr   <= w_ptr_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_ptr_next   = r_ptr;
    w_clear_wr   = 1'b0;
    w_clear_busy = 1'b0;
    w_req_ready  = 1'b0;
    case (r_state)
      ST_CLEAR: begin
        w_clear_busy = 1'b1;
        w_clear_wr   = 1'b1;
        w_ptr_next   = r_ptr + ADDR_WIDTH'(1);
        if (r_ptr == c_last_addr) begin
          w_state_next = ST_IDLE;
          w_ptr_next   = '0;
        end
      end
      ST_IDLE: begin
        if (bus.clear_start) begin
          w_state_next = ST_CLEAR;
          w_ptr_next   = '0;
        end else begin
          // A load may enter only if the output register is free or draining now.
          w_req_ready = ~w_is_ldr | ~r_resp_valid | bus.resp_ready;
        end
      end
      default: w_state_next = ST_CLEAR;
    endcase
  end

  always_ff @(posedge clock) begin
    if (w_clear_wr) begin
      r_mem[r_ptr] <= '0;
    end else if (w_str_acc && w_in_range) begin
      for (int i = 0; i < BE_WIDTH; i++) begin
        if (bus.req_be[i]) begin
          r_mem[bus.req_addr][i*8 +: 8] <= bus.req_wdata[i*8 +: 8];
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_resp_err   <= 1'b0;
      r_store_err  <= 1'b0;
    end else begin
      r_store_err <= w_str_acc & ~w_in_range;
      if (w_ldr_acc) begin
        r_resp_valid <= 1'b1;
        r_resp_err   <= ~w_in_range;
        r_resp_rdata <= w_in_range ? r_mem[bus.req_addr] : '0;
      end else if (bus.resp_ready) begin
        r_resp_valid <= 1'b0;
      end
    end
  end

  assign bus.req_ready  = w_req_ready;
  assign bus.clear_busy = w_clear_busy;
  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_rdata = r_resp_rdata;
  assign bus.resp_err   = r_resp_err;
  assign bus.store_err  = r_store_err;

endmodule

`default_nettype wire

// File: tb/tb_dcache_bank.sv
// +--------------------------------------------------------------------------+
// | tb_dcache_bank : directed and randomized checks of two dcache_bank       |
// |                  instances (DEPTH 32 and DEPTH 24) against a model       |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_dcache_bank;

  localparam logic [4:0] LDR = 5'd1;
  localparam logic [4:0] STR = 5'd2;
  localparam logic [4:0] NOP = 5'd0;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset_n = 1'b0;
  logic        sel     = 1'b0;
  logic        d_valid = 1'b0;
  logic [4:0]  d_uop   = '0;
  logic [4:0]  d_addr  = '0;
  logic [31:0] d_wdata = '0;
  logic [3:0]  d_be    = '0;
  logic        d_rready = 1'b0;
  logic        d_cs    = 1'b0;

  dcache_bank_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus_a ();
  dcache_bank_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus_b ();

  assign bus_a.req_valid   = d_valid & ~sel;
  assign bus_a.req_uop     = d_uop;
  assign bus_a.req_addr    = d_addr;
  assign bus_a.req_wdata   = d_wdata;
  assign bus_a.req_be      = d_be;
  assign bus_a.resp_ready  = d_rready & ~sel;
  assign bus_a.clear_start = d_cs & ~sel;
  assign bus_b.req_valid   = d_valid & sel;
  assign bus_b.req_uop     = d_uop;
  assign bus_b.req_addr    = d_addr;
  assign bus_b.req_wdata   = d_wdata;
  assign bus_b.req_be      = d_be;
  assign bus_b.resp_ready  = d_rready & sel;
  assign bus_b.clear_start = d_cs & sel;

  dcache_bank #(.DATA_WIDTH(32), .DEPTH(32), .ADDR_WIDTH(5), .LDR_UOP(LDR), .STR_UOP(STR)) u_bank_a (
    .clock(clock), .reset_n(reset_n), .bus(bus_a.slave));
  dcache_bank #(.DATA_WIDTH(32), .DEPTH(24), .ADDR_WIDTH(5), .LDR_UOP(LDR), .STR_UOP(STR)) u_bank_b (
    .clock(clock), .reset_n(reset_n), .bus(bus_b.slave));

  int checks = 0;
  int errors = 0;

  logic        obs_ready, obs_busy, obs_rvalid, obs_rerr, obs_serr;
  logic [31:0] obs_rdata;

  // Reference model: plain word array, outstanding-response queue, sweep countdown.
  logic [31:0] mdl_mem [32];
  int          mdl_depth = 32;
  int          clear_left = 0;
  bit          mdl_serr = 1'b0;
  logic [32:0] exp_q [$];

  task automatic tick(input bit v, input logic [4:0] uop, input logic [4:0] addr,
                      input logic [31:0] wd, input logic [3:0] be, input bit rr, input bit cs);
    d_valid = v; d_uop = uop; d_addr = addr; d_wdata = wd; d_be = be; d_rready = rr; d_cs = cs;
    #2;
    obs_ready  = sel ? bus_b.req_ready  : bus_a.req_ready;
    obs_busy   = sel ? bus_b.clear_busy : bus_a.clear_busy;
    obs_rvalid = sel ? bus_b.resp_valid : bus_a.resp_valid;
    obs_rdata  = sel ? bus_b.resp_rdata : bus_a.resp_rdata;
    obs_rerr   = sel ? bus_b.resp_err   : bus_a.resp_err;
    obs_serr   = sel ? bus_b.store_err  : bus_a.store_err;
    @(posedge clock);
    #1;
  endtask

  function automatic bit ready_exp(input logic [4:0] uop, input bit rr, input bit cs);
    return (clear_left == 0) && !cs && (uop != LDR || exp_q.size() == 0 || rr);
  endfunction

  task automatic model_update(input bit v, input logic [4:0] uop, input logic [4:0] addr,
                              input logic [31:0] wd, input logic [3:0] be, input bit rr, input bit cs);
    bit acc;
    acc = v && ready_exp(uop, rr, cs);
    if (exp_q.size() > 0 && rr) void'(exp_q.pop_front());
    if (clear_left > 0) clear_left--;
    else if (cs) begin
      clear_left = mdl_depth;
      foreach (mdl_mem[i]) mdl_mem[i] = '0;
    end
    mdl_serr = acc && uop == STR && int'(addr) >= mdl_depth;
    if (acc && uop == LDR)
      exp_q.push_back(int'(addr) < mdl_depth ? {1'b0, mdl_mem[addr]} : {1'b1, 32'h0});
    if (acc && uop == STR && int'(addr) < mdl_depth)
      for (int i = 0; i < 4; i++) if (be[i]) mdl_mem[addr][8*i +: 8] = wd[8*i +: 8];
  endtask

  task automatic cyc(input bit v, input logic [4:0] uop, input logic [4:0] addr,
                     input logic [31:0] wd, input logic [3:0] be, input bit rr, input bit cs);
    tick(v, uop, addr, wd, be, rr, cs);
    model_update(v, uop, addr, wd, be, rr, cs);
  endtask

  task automatic ldr(input logic [4:0] addr, output logic [31:0] data, output logic err, output logic vld);
    cyc(1'b1, LDR, addr, '0, '0, 1'b1, 1'b0);
    cyc(1'b0, NOP, '0, '0, '0, 1'b1, 1'b0);
    data = obs_rdata; err = obs_rerr; vld = obs_rvalid;
  endtask

  task automatic model_reset;
    clear_left = mdl_depth;
    exp_q.delete();
    mdl_serr = 1'b0;
    foreach (mdl_mem[i]) mdl_mem[i] = '0;
  endtask

  task automatic apply_reset;
    reset_n = 1'b0;
    tick(1'b0, NOP, '0, '0, '0, 1'b0, 1'b0);
    tick(1'b0, NOP, '0, '0, '0, 1'b0, 1'b0);
    reset_n = 1'b1;
    model_reset();
  endtask

  task automatic wait_sweep;
    int n = 0;
    do begin
      cyc(1'b0, NOP, '0, '0, '0, 1'b0, 1'b0);
      n++;
    end while (obs_busy && n < 200);
    checks++;
    if (obs_busy !== 1'b0) begin
      errors++;
      $display("FAIL sweep_timeout busy %b after %0d cycles, required 0", obs_busy, n);
    end
  endtask

  task automatic test_reset;
    int busy_cnt = 0, ready_bad = 0;
    logic [31:0] d; logic e, v;
    tick(1'b1, STR, 5'd0, '1, 4'hF, 1'b1, 1'b0);
    tick(1'b1, STR, 5'd0, '1, 4'hF, 1'b1, 1'b0);
    checks++; if (obs_busy !== 1'b1)   begin errors++; $display("FAIL rst_busy got %b exp 1", obs_busy); end
    checks++; if (obs_ready !== 1'b0)  begin errors++; $display("FAIL rst_ready got %b exp 0", obs_ready); end
    checks++; if (obs_rvalid !== 1'b0) begin errors++; $display("FAIL rst_rvalid got %b exp 0", obs_rvalid); end
    checks++; if (obs_rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata got %h exp 0", obs_rdata); end
    checks++; if (obs_rerr !== 1'b0)   begin errors++; $display("FAIL rst_rerr got %b exp 0", obs_rerr); end
    checks++; if (obs_serr !== 1'b0)   begin errors++; $display("FAIL rst_serr got %b exp 0", obs_serr); end
    reset_n = 1'b1;
    model_reset();
    for (int i = 0; i < 100; i++) begin
      cyc(i < 32, STR, 5'd0, '1, 4'hF, 1'b0, 1'b0);
      if (!obs_busy) break;
      busy_cnt++;
      if (obs_ready !== 1'b0) ready_bad++;
    end
    checks++; if (busy_cnt != 32) begin errors++; $display("FAIL sweep_len got %0d exp 32", busy_cnt); end
    checks++; if (ready_bad != 0) begin errors++; $display("FAIL sweep_ready got %0d ready cycles exp 0", ready_bad); end
    checks++; if (obs_ready !== 1'b1) begin errors++; $display("FAIL idle_ready got %b exp 1", obs_ready); end
    for (int a = 0; a < 32; a++) begin
      ldr(5'(a), d, e, v);
      checks++;
      if (v !== 1'b1 || e !== 1'b0 || d !== 32'h0) begin
        errors++; $display("FAIL zero_read addr %0d got v%b e%b %h exp v1 e0 0", a, v, e, d);
      end
    end
  endtask

  task automatic test_byte_enable;
    cyc(1'b1, STR, 5'd5, 32'hDEADBEEF, 4'b1111, 1'b1, 1'b0);
    cyc(1'b1, STR, 5'd5, 32'h000000AA, 4'b0001, 1'b1, 1'b0);
    tick(1'b1, LDR, 5'd5, '0, '0, 1'b0, 1'b0);
    checks++;
    if (obs_ready !== 1'b1 || obs_rvalid !== 1'b0) begin
      errors++; $display("FAIL be_accept got ready %b rvalid %b exp 1 0", obs_ready, obs_rvalid);
    end
    model_update(1'b1, LDR, 5'd5, '0, '0, 1'b0, 1'b0);
    tick(1'b0, NOP, '0, '0, '0, 1'b0, 1'b0);
    checks++;
    if (obs_rvalid !== 1'b1 || obs_rdata !== 32'hDEADBEAA || obs_rerr !== 1'b0) begin
      errors++; $display("FAIL be_merge got v%b %h e%b exp v1 deadbeaa e0", obs_rvalid, obs_rdata, obs_rerr);
    end
    model_update(1'b0, NOP, '0, '0, '0, 1'b0, 1'b0);
    cyc(1'b0, NOP, '0, '0, '0, 1'b1, 1'b0);
    cyc(1'b0, NOP, '0, '0, '0, 1'b1, 1'b0);
    checks++; if (obs_rvalid !== 1'b0) begin errors++; $display("FAIL be_drain got %b exp 0", obs_rvalid); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] w [3];
    logic [31:0] got [$];
    logic [4:0]  uops  [8] = '{LDR, LDR, LDR, LDR, LDR, LDR, NOP, NOP};
    logic [4:0]  addrs [8] = '{5'd1, 5'd2, 5'd2, 5'd2, 5'd2, 5'd3, 5'd0, 5'd0};
    bit          rrs   [8] = '{0, 0, 0, 0, 1, 1, 1, 1};
    bit          rdy   [8] = '{1, 0, 0, 0, 1, 1, 1, 1};
    int          rdy_bad = 0, hold_bad = 0;
    for (int i = 0; i < 3; i++) begin
      w[i] = $urandom;
      cyc(1'b1, STR, 5'(i + 1), w[i], 4'hF, 1'b1, 1'b0);
    end
    for (int k = 0; k < 8; k++) begin
      tick(k < 6, uops[k], addrs[k], '0, '0, rrs[k], 1'b0);
      if (obs_ready !== rdy[k]) rdy_bad++;
      if (k >= 1 && k <= 3 && (obs_rvalid !== 1'b1 || obs_rdata !== w[0])) hold_bad++;
      if (obs_rvalid === 1'b1 && rrs[k]) got.push_back(obs_rdata);
      model_update(k < 6, uops[k], addrs[k], '0, '0, rrs[k], 1'b0);
    end
    checks++; if (rdy_bad != 0)  begin errors++; $display("FAIL b2b_ready got %0d wrong cycles exp 0", rdy_bad); end
    checks++; if (hold_bad != 0) begin errors++; $display("FAIL b2b_hold got %0d unstable cycles exp 0", hold_bad); end
    checks++;
    if (got.size() != 3) begin
      errors++; $display("FAIL b2b_count got %0d responses exp 3", got.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (got[i] !== w[i]) begin errors++; $display("FAIL b2b_order idx %0d got %h exp %h", i, got[i], w[i]); end
      end
    end
    checks++; if (obs_rvalid !== 1'b0) begin errors++; $display("FAIL b2b_drain got %b exp 0", obs_rvalid); end
  endtask

  task automatic test_clear;
    int busy_cnt = 0, ready_bad = 0, hold_bad = 0, drop_bad = 0;
    logic [31:0] held, d; logic e, v;
    cyc(1'b1, STR, 5'd3, 32'h12345678, 4'hF, 1'b1, 1'b0);
    held = mdl_mem[7];
    cyc(1'b1, LDR, 5'd7, '0, '0, 1'b0, 1'b0);
    tick(1'b1, STR, 5'd3, 32'hCAFEF00D, 4'hF, 1'b0, 1'b1);
    checks++; if (obs_ready !== 1'b0) begin errors++; $display("FAIL clear_prio got ready %b exp 0", obs_ready); end
    model_update(1'b1, STR, 5'd3, 32'hCAFEF00D, 4'hF, 1'b0, 1'b1);
    for (int i = 0; i < 100; i++) begin
      cyc(1'b1, STR, 5'd3, 32'hCAFEF00D, 4'h0, 1'b0, 1'b0);
      if (!obs_busy) break;
      busy_cnt++;
      if (obs_ready !== 1'b0) ready_bad++;
      if (obs_rvalid !== 1'b1 || obs_rdata !== held) hold_bad++;
    end
    checks++; if (busy_cnt != 32) begin errors++; $display("FAIL clear_len got %0d exp 32", busy_cnt); end
    checks++; if (ready_bad != 0) begin errors++; $display("FAIL clear_ready got %0d exp 0", ready_bad); end
    checks++; if (hold_bad != 0)  begin errors++; $display("FAIL clear_hold got %0d exp 0", hold_bad); end
    cyc(1'b0, NOP, '0, '0, '0, 1'b1, 1'b0);
    ldr(5'd3, d, e, v);
    checks++; if (v !== 1'b1 || d !== 32'h0) begin errors++; $display("FAIL clear_word3 got v%b %h exp v1 0", v, d); end
    cyc(1'b1, LDR, 5'd4, '0, '0, 1'b0, 1'b0);
    cyc(1'b0, NOP, '0, '0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) cyc(1'b0, NOP, '0, '0, '0, 1'b0, 1'b0);
    reset_n = 1'b0;
    tick(1'b0, NOP, '0, '0, '0, 1'b0, 1'b0);
    tick(1'b0, NOP, '0, '0, '0, 1'b0, 1'b0);
    reset_n = 1'b1;
    model_reset();
    busy_cnt = 0;
    for (int i = 0; i < 100; i++) begin
      cyc(1'b0, NOP, '0, '0, '0, 1'b0, 1'b0);
      if (obs_rvalid !== 1'b0) drop_bad++;
      if (!obs_busy) break;
      busy_cnt++;
    end
    checks++; if (busy_cnt != 32) begin errors++; $display("FAIL rst_restart got %0d exp 32", busy_cnt); end
    checks++; if (drop_bad != 0)  begin errors++; $display("FAIL rst_drop got %0d valid cycles exp 0", drop_bad); end
  endtask

  task automatic test_out_of_range;
    logic [31:0] d; logic e, v;
    for (int a = 0; a < 24; a++) cyc(1'b1, STR, 5'(a), $urandom | 32'h1, 4'hF, 1'b1, 1'b0);
    ldr(5'd23, d, e, v);
    checks++;
    if (v !== 1'b1 || e !== 1'b0 || d !== mdl_mem[23]) begin
      errors++; $display("FAIL oor_last got v%b e%b %h exp v1 e0 %h", v, e, d, mdl_mem[23]);
    end
    ldr(5'd24, d, e, v);
    checks++;
    if (v !== 1'b1 || e !== 1'b1 || d !== 32'h0) begin
      errors++; $display("FAIL oor_24 got v%b e%b %h exp v1 e1 0", v, e, d);
    end
    ldr(5'd10, d, e, v);
    ldr(5'd30, d, e, v);
    checks++;
    if (v !== 1'b1 || e !== 1'b1 || d !== 32'h0) begin
      errors++; $display("FAIL oor_ldr30 got v%b e%b %h exp v1 e1 0", v, e, d);
    end
    tick(1'b1, STR, 5'd30, 32'hFFFFFFFF, 4'hF, 1'b1, 1'b0);
    checks++;
    if (obs_ready !== 1'b1 || obs_serr !== 1'b0) begin
      errors++; $display("FAIL oor_str_acc got ready %b serr %b exp 1 0", obs_ready, obs_serr);
    end
    model_update(1'b1, STR, 5'd30, 32'hFFFFFFFF, 4'hF, 1'b1, 1'b0);
    cyc(1'b0, NOP, '0, '0, '0, 1'b1, 1'b0);
    checks++; if (obs_serr !== 1'b1) begin errors++; $display("FAIL oor_serr_pulse got %b exp 1", obs_serr); end
    cyc(1'b0, NOP, '0, '0, '0, 1'b1, 1'b0);
    checks++; if (obs_serr !== 1'b0) begin errors++; $display("FAIL oor_serr_once got %b exp 0", obs_serr); end
    for (int a = 0; a < 24; a++) begin
      ldr(5'(a), d, e, v);
      checks++;
      if (v !== 1'b1 || e !== 1'b0 || d !== mdl_mem[a]) begin
        errors++; $display("FAIL oor_intact addr %0d got %h exp %h", a, d, mdl_mem[a]);
      end
    end
  endtask

  task automatic test_random(input int n);
    bit v, rr, cs; logic [4:0] uop, addr; logic [31:0] wd; logic [3:0] be; int r;
    for (int c = 0; c < n; c++) begin
      v = ($urandom % 4) != 0;
      r = $urandom % 8;
      uop = (r < 3) ? LDR : (r < 6) ? STR : ((r == 6) ? NOP : 5'($urandom_range(3, 31)));
      addr = 5'($urandom % 32);
      wd = $urandom; be = 4'($urandom); rr = ($urandom % 3) != 0; cs = ($urandom % 80) == 0;
      tick(v, uop, addr, wd, be, rr, cs);
      checks++;
      if (obs_ready !== ready_exp(uop, rr, cs)) begin
        errors++; $display("FAIL rand_ready cyc %0d got %b exp %b", c, obs_ready, ready_exp(uop, rr, cs));
      end
      checks++;
      if (obs_busy !== (clear_left > 0)) begin
        errors++; $display("FAIL rand_busy cyc %0d got %b exp %b", c, obs_busy, clear_left > 0);
      end
      checks++;
      if (obs_rvalid !== (exp_q.size() > 0)) begin
        errors++; $display("FAIL rand_rvalid cyc %0d got %b exp %b", c, obs_rvalid, exp_q.size() > 0);
      end else if (exp_q.size() > 0) begin
        checks++;
        if ({obs_rerr, obs_rdata} !== exp_q[0]) begin
          errors++; $display("FAIL rand_resp cyc %0d got e%b %h exp e%b %h", c, obs_rerr, obs_rdata, exp_q[0][32], exp_q[0][31:0]);
        end
      end
      checks++;
      if (obs_serr !== mdl_serr) begin
        errors++; $display("FAIL rand_serr cyc %0d got %b exp %b", c, obs_serr, mdl_serr);
      end
      model_update(v, uop, addr, wd, be, rr, cs);
    end
  endtask

  initial begin
    @(posedge clock);
    #1;
    test_reset();
    test_byte_enable();
    test_back_to_back();
    test_clear();
    test_random(800);
    sel = 1'b1;
    mdl_depth = 24;
    apply_reset();
    wait_sweep();
    test_out_of_range();
    test_random(800);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
